// File: rtl/uart_rx_16x_pkg.sv
// +-------------------------------------------------------------------------+
// | uart_rx_16x_pkg : shared 16x-oversampled UART constants and helpers      |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
`default_nettype none

package uart_rx_16x_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int TICK_W     = $clog2(OVERSAMPLE);

  localparam logic [TICK_W-1:0] SAMPLE_T0 = 4'd7;
  localparam logic [TICK_W-1:0] SAMPLE_T1 = 4'd8;
  localparam logic [TICK_W-1:0] SAMPLE_T2 = 4'd9;
  localparam logic [TICK_W-1:0] LAST_TICK = 4'd15;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync_vote.sv
// +-------------------------------------------------------------------------+
// | uart_rx_sync_vote : rx synchroniser plus 3-sample mid-bit majority vote  |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
`default_nettype none

module uart_rx_sync_vote
  import uart_rx_16x_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable_16,
  input  logic              rx,
  input  logic [TICK_W-1:0] tick,
  output logic              rx_s,
  output logic              bit_value
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [1:0]             samples;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_q  <= '1;
      samples <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      if (enable_16 && (tick == SAMPLE_T0 || tick == SAMPLE_T1))
        samples <= {samples[0], rx_s};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Third sample is the live rx_s, so the vote is ready on the tick-9 strobe itself.
  assign bit_value = majority3(samples[1], samples[0], rx_s);

endmodule

`default_nettype wire

// File: rtl/uart_rx_16x.sv
// +-------------------------------------------------------------------------+
// | uart_rx_16x : 16x-oversampling UART receiver with valid/ready output     |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
`default_nettype none

module uart_rx_16x
  import uart_rx_16x_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable_16,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_error,
  output logic                 overrun,
  input  logic                 clear_errors,
  output logic                 busy
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  logic [2:0]           state, state_next;
  logic [TICK_W-1:0]    tick_cnt, tick_now;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 rx_s, bit_value;
  logic                 at_vote, at_last, deliver, stop_bad, ovr_set;

  uart_rx_sync_vote #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_vote (
    .clk       (clk),
    .resetn    (resetn),
    .enable_16 (enable_16),
    .rx        (rx),
    .tick      (tick_now),
    .rx_s      (rx_s),
    .bit_value (bit_value)
  );

  // tick_cnt holds the index of the last processed strobe; tick_now is this strobe's index.
  assign tick_now = tick_cnt + 1'b1;
  assign at_vote  = enable_16 && (tick_now == SAMPLE_T2);
  assign at_last  = enable_16 && (tick_now == LAST_TICK);
  assign deliver  = (state == ST_STOP) && at_vote && bit_value;
  assign stop_bad = (state == ST_STOP) && at_vote && !bit_value;
  assign ovr_set  = deliver && out_valid && !out_ready;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (enable_16 && !rx_s) state_next = ST_START;
      ST_START: begin
        if (at_vote && bit_value) state_next = ST_IDLE;
        else if (at_last)         state_next = ST_DATA;
      end
      ST_DATA:      if (at_last && bit_cnt == LAST_BIT) state_next = ST_STOP;
      ST_STOP:      if (at_vote) state_next = bit_value ? ST_IDLE : ST_WAIT_IDLE;
      ST_WAIT_IDLE: if (enable_16 && rx_s) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != ST_IDLE);

      // The detecting strobe counts as tick 0, so entering START loads zero.
      if (enable_16) begin
        if (state != ST_IDLE &&
            (state_next == ST_START || state_next == ST_DATA || state_next == ST_STOP))
          tick_cnt <= tick_now;
        else
          tick_cnt <= '0;
      end

      if (state == ST_START && at_last)
        bit_cnt <= '0;
      else if (state == ST_DATA && at_last && bit_cnt != LAST_BIT)
        bit_cnt <= bit_cnt + 1'b1;

      if (state == ST_DATA && at_vote)
        shreg <= {bit_value, shreg[DATA_BITS-1:1]};

      if (deliver && (!out_valid || out_ready)) begin
        out_data  <= shreg;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (stop_bad)          frame_error <= 1'b1;
      else if (clear_errors) frame_error <= 1'b0;

      if (ovr_set)           overrun <= 1'b1;
      else if (clear_errors) overrun <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_16x.sv
// +-------------------------------------------------------------------------+
// | tb_uart_rx_16x : directed + randomized bench with byte-queue reference   |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx_16x;

  logic       clk = 1'b0;
  logic       resetn;
  logic       enable_16;
  logic       rx;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       frame_error;
  logic       overrun;
  logic       clear_errors;
  logic       busy;

  int         checks   = 0;
  int         failures = 0;
  int         en_period = 1;
  int         en_cnt    = 0;
  logic [7:0] exp_q[$];

  uart_rx_16x #(
    .DATA_BITS   (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .enable_16    (enable_16),
    .rx           (rx),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .frame_error  (frame_error),
    .overrun      (overrun),
    .clear_errors (clear_errors),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    rx = 1'b0;
    wait_clks(16 * en_period);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clks(16 * en_period);
    end
    rx = stop_b;
    wait_clks(16 * en_period);
  endtask

  task automatic pulse_clear();
    clear_errors = 1'b1;
    wait_clks(1);
    clear_errors = 1'b0;
  endtask

  // Strobe generator: one-clk pulse every en_period clks.
  initial begin
    enable_16 = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      en_cnt    = (en_cnt + 1 >= en_period) ? 0 : en_cnt + 1;
      enable_16 = (en_cnt == 0);
    end
  end

  // Every accepted byte must be the oldest expected one.
  always @(negedge clk) begin
    if (resetn && out_valid && out_ready) begin
      check("byte_avail", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("rx_byte", out_data, exp_q.pop_front());
    end
  end

  initial begin
    logic       held, fe_exp, ov_exp, rdy, bad;
    logic [7:0] d;

    resetn = 1'b0; rx = 1'b1; out_ready = 1'b1; clear_errors = 1'b0;
    wait_clks(5);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_ferr", frame_error, 0);
    check("rst_ovr", overrun, 0);
    check("rst_busy", busy, 0);
    resetn = 1'b1;
    wait_clks(10);

    // Back-to-back frames at one strobe per clk.
    en_period = 1;
    exp_q.push_back(8'h55); send_frame(8'h55, 1'b1);
    exp_q.push_back(8'hA3); send_frame(8'hA3, 1'b1);
    wait_clks(20);
    check("t1_drained", exp_q.size(), 0);
    check("t1_ferr", frame_error, 0);
    check("t1_ovr", overrun, 0);
    check("t1_valid", out_valid, 0);

    // False start.
    en_period = 4;
    wait_clks(8);
    rx = 1'b0;
    wait_clks(24);
    rx = 1'b1;
    check("t2_busy_mid", busy, 1);
    wait_clks(80);
    check("t2_busy_end", busy, 0);
    check("t2_valid", out_valid, 0);
    check("t2_ferr", frame_error, 0);

    // Framing error, line held low, recovery.
    en_period = 1;
    wait_clks(8);
    send_frame(8'h3C, 1'b0);
    wait_clks(40);
    check("t3_ferr", frame_error, 1);
    check("t3_valid", out_valid, 0);
    check("t3_busy_low", busy, 1);
    rx = 1'b1;
    wait_clks(2);
    check("t3_busy_sync", busy, 1);
    wait_clks(1);
    check("t3_busy_rel", busy, 0);
    wait_clks(10);
    exp_q.push_back(8'h81); send_frame(8'h81, 1'b1);
    wait_clks(20);
    check("t3_drained", exp_q.size(), 0);
    check("t3_ferr_sticky", frame_error, 1);
    pulse_clear();
    check("t3_ferr_clr", frame_error, 0);

    // Overrun while consumer stalls.
    out_ready = 1'b0;
    exp_q.push_back(8'h11); send_frame(8'h11, 1'b1);
    wait_clks(4);
    send_frame(8'h22, 1'b1);
    wait_clks(10);
    check("t4_valid", out_valid, 1);
    check("t4_data", out_data, 8'h11);
    check("t4_ovr", overrun, 1);
    out_ready = 1'b1;
    wait_clks(3);
    check("t4_valid_after", out_valid, 0);
    check("t4_drained", exp_q.size(), 0);
    pulse_clear();
    check("t4_ovr_clr", overrun, 0);

    // Consume exactly on the delivery clk of the next frame: no overrun.
    out_ready = 1'b0;
    exp_q.push_back(8'h11); send_frame(8'h11, 1'b1);
    wait_clks(10);
    check("t5_held", out_valid, 1);
    exp_q.push_back(8'h22);
    fork
      send_frame(8'h22, 1'b1);
      begin
        wait_clks(155);
        out_ready = 1'b1;
        wait_clks(1);
        out_ready = 1'b0;
      end
    join
    wait_clks(10);
    check("t5_data", out_data, 8'h22);
    check("t5_valid", out_valid, 1);
    check("t5_ovr", overrun, 0);
    out_ready = 1'b1;
    wait_clks(3);
    check("t5_drained", exp_q.size(), 0);

    // Randomized frames; reference is a one-slot holding model.
    held = 1'b0; fe_exp = 1'b0; ov_exp = 1'b0;
    for (int k = 0; k < 12; k++) begin
      en_period = $urandom_range(1, 4);
      wait_clks(4 * en_period);
      rdy = 1'($urandom_range(0, 1));
      out_ready = rdy;
      if (rdy) held = 1'b0;
      d   = 8'($urandom);
      bad = ($urandom_range(0, 5) == 0);
      if (bad) fe_exp = 1'b1;
      else if (!held || rdy) begin
        exp_q.push_back(d);
        held = !rdy;
      end else ov_exp = 1'b1;
      send_frame(d, !bad);
      rx = 1'b1;
      wait_clks(16 * en_period * $urandom_range(1, 3));
      check("rnd_ferr", frame_error, fe_exp);
      check("rnd_ovr", overrun, ov_exp);
    end
    out_ready = 1'b1;
    wait_clks(10);
    check("rnd_drained", exp_q.size(), 0);
    pulse_clear();

    // Reset during data bit 4 of 0xF0, then a clean frame.
    en_period = 2;
    wait_clks(8);
    fork
      send_frame(8'hF0, 1'b1);
      begin
        wait_clks(176);
        resetn = 1'b0;
        wait_clks(1);
        resetn = 1'b1;
        check("t6_valid", out_valid, 0);
        check("t6_data", out_data, 0);
        check("t6_busy", busy, 0);
        check("t6_ferr", frame_error, 0);
        check("t6_ovr", overrun, 0);
      end
    join
    wait_clks(20);
    exp_q.push_back(8'h0F); send_frame(8'h0F, 1'b1);
    wait_clks(40);
    check("t6_drained", exp_q.size(), 0);
    check("t6_valid_end", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
